// File: rtl/commit_bus_arbiter_pkg.sv
// Shared sizes and index helpers for the commit bus arbiter.
// Optional statistics counters in the top are enabled by defining COMMIT_ARB_STATS_EN.
package commit_bus_arbiter_pkg;

    localparam int COMMIT_PACKET_SIZE      = 32;
    localparam int COMMIT_ARB_NUM_STATIONS = 8;
    localparam int COMMIT_ARB_ID_W         = 4;

    // Station index reached by stepping `off` places from `base`, wrapping at n.
    function automatic int rrIdx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/commit_bus_arbiter_if.sv
// Commit bus between the reservation-station array and the writeback path.
// master = arbiter side, slave = station/writeback side.
interface commit_bus_arbiter_if
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE,
    parameter int ID_W         = COMMIT_ARB_ID_W
);
    logic [NUM_STATIONS-1:0]          iCommitRequest;
    logic [NUM_STATIONS*PACKET_W-1:0] iCommitData;
    logic                             iCommitStall;
    logic [NUM_STATIONS-1:0]          oCommitGranted;
    logic [PACKET_W-1:0]              oCommitData;
    logic                             oCommitValid;
    logic [ID_W-1:0]                  oCommitId;

    modport master (
        input  iCommitRequest, iCommitData, iCommitStall,
        output oCommitGranted, oCommitData, oCommitValid, oCommitId
    );

    modport slave (
        output iCommitRequest, iCommitData, iCommitStall,
        input  oCommitGranted, oCommitData, oCommitValid, oCommitId
    );
endinterface

// File: rtl/commit_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of eReq scanning upward from rPtr with wrap.
module rr_priority_picker
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int ID_W         = COMMIT_ARB_ID_W
) (
    input  logic [NUM_STATIONS-1:0] eReq,
    input  logic [ID_W-1:0]         rPtr,
    output logic                    found,
    output logic [ID_W-1:0]         winnerIdx,
    output logic [NUM_STATIONS-1:0] winnerOneHot
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found        = 1'b0;
        winnerIdx    = '0;
        winnerOneHot = '0;
        idx          = 0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            idx = rrIdx(int'(rPtr), i, NUM_STATIONS);
            if (!found && eReq[idx]) begin
                found             = 1'b1;
                winnerIdx         = ID_W'(idx);
                winnerOneHot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Round-robin arbiter sharing one commit bus among NUM_STATIONS reservation stations.
// Define COMMIT_ARB_STATS_EN to add the oGrantCount / oStallCount statistics ports.
module commit_bus_arbiter
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE,
    parameter int ID_W         = COMMIT_ARB_ID_W
) (
    input  logic                 Clock,
    input  logic                 Reset,
    commit_bus_arbiter_if.master bus
`ifdef COMMIT_ARB_STATS_EN
    ,
    output logic [31:0]          oGrantCount,
    output logic [31:0]          oStallCount
`endif
);

    logic [ID_W-1:0]         rPtr;
    logic [NUM_STATIONS-1:0] rLastMask;
    logic [NUM_STATIONS-1:0] eReq;
    logic                    found;
    logic [ID_W-1:0]         winnerIdx;
    logic [NUM_STATIONS-1:0] winnerOneHot;
    logic                    grantNow;
    logic [PACKET_W-1:0]     winnerPacket;

    logic [NUM_STATIONS-1:0] rGranted;
    logic                    rValid;
    logic [PACKET_W-1:0]     rData;
    logic [ID_W-1:0]         rId;

    // The previous winner may still show its request while its grant is visible.
    assign eReq         = bus.iCommitRequest & ~rLastMask;
    assign grantNow     = found && !bus.iCommitStall;
    assign winnerPacket = bus.iCommitData[winnerIdx*PACKET_W +: PACKET_W];

    rr_priority_picker #(
        .NUM_STATIONS (NUM_STATIONS),
        .ID_W         (ID_W)
    ) uPicker (
        .eReq         (eReq),
        .rPtr         (rPtr),
        .found        (found),
        .winnerIdx    (winnerIdx),
        .winnerOneHot (winnerOneHot)
    );

    // NOTE: Reset is sampled only on the clock edge; state uses non-blocking assignments.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rPtr      <= '0;
            rLastMask <= '0;
            rGranted  <= '0;
            rValid    <= 1'b0;
            rData     <= '0;
            rId       <= '0;
        end else if (grantNow) begin
            rPtr      <= ID_W'(rrIdx(int'(winnerIdx), 1, NUM_STATIONS));
            rLastMask <= winnerOneHot;
            rGranted  <= winnerOneHot;
            rValid    <= 1'b1;
            rData     <= winnerPacket;
            rId       <= winnerIdx;
        end else begin
            rLastMask <= '0;
            rGranted  <= '0;
            rValid    <= 1'b0;
        end
    end

    assign bus.oCommitGranted = rGranted;
    assign bus.oCommitValid   = rValid;
    assign bus.oCommitData    = rData;
    assign bus.oCommitId      = rId;

`ifdef COMMIT_ARB_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oGrantCount <= '0;
            oStallCount <= '0;
        end else begin
            if (grantNow)
                oGrantCount <= oGrantCount + 32'd1;
            if (bus.iCommitStall && |bus.iCommitRequest)
                oStallCount <= oStallCount + 32'd1;
        end
    end
`endif

endmodule
